// File: rtl/ir_nec_rx.sv
// ir_nec_rx: NEC infrared protocol receiver.
//
// Decodes the demodulated output of an IR receiver module into 32-bit NEC
// frames and repeat codes. The input is synchronized, glitch filtered on a
// 1 us time base, and every mark/space duration is measured and classified
// by a small FSM when the phase ends.
//
// Parameters
//   CLK_HZ      system clock frequency; 1 us tick = CLK_HZ/1000000 clocks
//   GLITCH_US   ticks the input must be stable before a level is accepted
//   TIMEOUT_US  longest space tolerated inside a frame
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   i_ir_rxb    asynchronous IR receiver output, active low (low = mark)
//   o_data      last accepted frame {~cmd, cmd, ~addr, addr}, first bit in [0]
//   o_valid     one-clock pulse when o_data takes a new frame
//   o_repeat    one-clock pulse on an accepted repeat code
//   o_err       one-clock pulse on an aborted frame
//
// Build option
//   IR_NEC_CHECKSUM_EN  when defined, a frame is accepted only if
//                       byte1 == ~byte0 and byte3 == ~byte2.

module ir_nec_rx #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned GLITCH_US  = 4,
   parameter int unsigned TIMEOUT_US = 12000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ir_rxb,
   output logic [31:0] o_data,
   output logic        o_valid,
   output logic        o_repeat,
   output logic        o_err
);

   // Tick divider sizing; a clock slower than 1 MHz ticks every cycle.
   localparam int unsigned DIV_RAW = CLK_HZ / 1000000;
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

   // Glitch filter sizing; at least one tick of stability is required.
   localparam int unsigned GF      = (GLITCH_US < 1) ? 1 : GLITCH_US;
   localparam int unsigned GW      = $clog2(GF + 1);

   localparam int unsigned DUR_W   = 16;
   localparam int unsigned IDX_W   = 5;

   // Inclusive duration windows in microseconds.
   localparam logic [DUR_W-1:0] LEAD_MARK_MIN  = DUR_W'(8000);
   localparam logic [DUR_W-1:0] LEAD_MARK_MAX  = DUR_W'(10000);
   localparam logic [DUR_W-1:0] LEAD_SPACE_MIN = DUR_W'(4000);
   localparam logic [DUR_W-1:0] LEAD_SPACE_MAX = DUR_W'(5000);
   localparam logic [DUR_W-1:0] RPT_SPACE_MIN  = DUR_W'(2000);
   localparam logic [DUR_W-1:0] RPT_SPACE_MAX  = DUR_W'(2500);
   localparam logic [DUR_W-1:0] BIT_MARK_MIN   = DUR_W'(400);
   localparam logic [DUR_W-1:0] BIT_MARK_MAX   = DUR_W'(700);
   localparam logic [DUR_W-1:0] ZERO_MIN       = DUR_W'(400);
   localparam logic [DUR_W-1:0] ZERO_MAX       = DUR_W'(700);
   localparam logic [DUR_W-1:0] ONE_MIN        = DUR_W'(1400);
   localparam logic [DUR_W-1:0] ONE_MAX        = DUR_W'(1900);
   localparam logic [DUR_W-1:0] TIMEOUT_LIM    = DUR_W'(TIMEOUT_US);
   localparam logic [DUR_W-1:0] DUR_SAT        = {DUR_W{1'b1}};
   localparam logic [IDX_W-1:0] LAST_BIT       = IDX_W'(31);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LEAD_MARK  = 3'd1,
      LEAD_SPACE = 3'd2,
      BIT_MARK   = 3'd3,
      BIT_SPACE  = 3'd4,
      RPT_MARK   = 3'd5
   } state_t;

   function automatic logic in_win(input logic [DUR_W-1:0] d,
                                   input logic [DUR_W-1:0] lo,
                                   input logic [DUR_W-1:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_sync;
   logic             r_filt;
   logic [GW-1:0]    r_gcnt;
   logic             r_m_q;
   logic [DUR_W-1:0] r_dur;
   state_t           r_state;
   logic [30:0]      r_shift;
   logic [IDX_W-1:0] r_idx;
   logic             r_seen;

   logic             w_tick;
   logic             w_m;
   logic             w_rise;
   logic             w_fall;
   logic             w_bit0;
   logic             w_bit1;
   logic [31:0]      w_frame;
   logic             w_csum_ok;
   state_t           w_state_nxt;
   logic             w_shift_en;
   logic             w_idx_clr;
   logic             w_load;
   logic             w_rpt;
   logic             w_err;

   // 1 us tick divider.
   assign w_tick = (r_div == DIV_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Two-flop synchronizer and glitch filter, both parked at the idle-high
   // level so leaving reset never manufactures an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= 2'b11;
         r_filt <= 1'b1;
         r_gcnt <= '0;
      end else begin
         r_sync <= {r_sync[0], i_ir_rxb};
         if (w_tick) begin
            if (r_sync[1] == r_filt) begin
               r_gcnt <= '0;
            end else if (r_gcnt == GW'(GF - 1)) begin
               r_filt <= r_sync[1];
               r_gcnt <= '0;
            end else begin
               r_gcnt <= r_gcnt + GW'(1);
            end
         end
      end
   end

   // Filtered mark level and its edges.
   assign w_m    = ~r_filt;
   assign w_rise = w_m & ~r_m_q;
   assign w_fall = ~w_m & r_m_q;

   // Saturating duration of the current phase; on an edge cycle it still
   // holds the length of the phase that just ended.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_q <= 1'b0;
         r_dur <= '0;
      end else begin
         r_m_q <= w_m;
         if (w_rise || w_fall) begin
            r_dur <= '0;
         end else if (w_tick && (r_dur != DUR_SAT)) begin
            r_dur <= r_dur + DUR_W'(1);
         end
      end
   end

   // Bit classification and the frame as it would look with this bit added.
   assign w_bit0  = in_win(r_dur, ZERO_MIN, ZERO_MAX);
   assign w_bit1  = in_win(r_dur, ONE_MIN, ONE_MAX);
   assign w_frame = {w_bit1, r_shift};

`ifdef IR_NEC_CHECKSUM_EN
   assign w_csum_ok = (w_frame[15:8]  == ~w_frame[7:0]) &&
                      (w_frame[31:24] == ~w_frame[23:16]);
`else
   assign w_csum_ok = 1'b1;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and datapath controls; phases are judged when they end.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_idx_clr   = 1'b0;
      w_load      = 1'b0;
      w_rpt       = 1'b0;
      w_err       = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt = LEAD_MARK;
            end
         end
         LEAD_MARK: begin
            if (w_fall) begin
               if (in_win(r_dur, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                  w_state_nxt = LEAD_SPACE;
               end else begin
                  w_state_nxt = IDLE;
                  w_err       = 1'b1;
               end
            end
         end
         LEAD_SPACE: begin
            if (w_rise) begin
               if (in_win(r_dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                  w_state_nxt = BIT_MARK;
                  w_idx_clr   = 1'b1;
               end else if (in_win(r_dur, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                  w_state_nxt = RPT_MARK;
               end else begin
                  w_state_nxt = IDLE;
                  w_err       = 1'b1;
               end
            end
         end
         BIT_MARK: begin
            if (w_fall) begin
               if (in_win(r_dur, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                  w_state_nxt = BIT_SPACE;
               end else begin
                  w_state_nxt = IDLE;
                  w_err       = 1'b1;
               end
            end
         end
         BIT_SPACE: begin
            if (w_rise) begin
               if (w_bit0 || w_bit1) begin
                  w_shift_en = 1'b1;
                  if (r_idx == LAST_BIT) begin
                     // Final bit: the stop mark now in progress is ignored.
                     w_state_nxt = IDLE;
                     if (w_csum_ok) begin
                        w_load = 1'b1;
                     end else begin
                        w_err  = 1'b1;
                     end
                  end else begin
                     w_state_nxt = BIT_MARK;
                  end
               end else begin
                  w_state_nxt = IDLE;
                  w_err       = 1'b1;
               end
            end
         end
         RPT_MARK: begin
            if (w_fall) begin
               w_state_nxt = IDLE;
               if (in_win(r_dur, BIT_MARK_MIN, BIT_MARK_MAX) && r_seen) begin
                  w_rpt = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // A space that runs too long aborts without waiting for the next edge.
      if ((r_state != IDLE) && !w_m && (r_dur > TIMEOUT_LIM)) begin
         w_state_nxt = IDLE;
         w_shift_en  = 1'b0;
         w_idx_clr   = 1'b0;
         w_load      = 1'b0;
         w_rpt       = 1'b0;
         w_err       = 1'b1;
      end
   end

   // Shift register, bit index, registered outputs and frame-seen flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift  <= '0;
         r_idx    <= '0;
         r_seen   <= 1'b0;
         o_data   <= '0;
         o_valid  <= 1'b0;
         o_repeat <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         o_valid  <= w_load;
         o_repeat <= w_rpt;
         o_err    <= w_err;
         if (w_idx_clr) begin
            r_shift <= '0;
            r_idx   <= '0;
         end else if (w_shift_en) begin
            r_shift <= w_frame[31:1];
            r_idx   <= r_idx + IDX_W'(1);
         end
         if (w_load) begin
            o_data <= w_frame;
            r_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb_ir_nec_rx: directed bench for ir_nec_rx. Several receiver instances run
// side by side, each fed its own IR waveform, so that multi-frame scenarios
// fit in a short run. The clock is 1 MHz nominal so one tick is one cycle.

`timescale 1ns/1ps

module tb_ir_nec_rx;

   localparam int unsigned NL = 5;

   logic        clk = 1'b0;
   logic        rst_l   [NL];
   logic        ir_l    [NL];
   logic [31:0] data_l  [NL];
   logic        valid_l [NL];
   logic        rpt_l   [NL];
   logic        err_l   [NL];

   int n_valid [NL];
   int n_rpt   [NL];
   int n_err   [NL];
   int err_cyc [NL];
   int cyc;
   int n_multi;
   int n_assert;
   int n_fail;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : g_lane
      ir_nec_rx #(
         .CLK_HZ     (1000000),
         .GLITCH_US  (4),
         .TIMEOUT_US (12000)
      ) u_dut (
         .clk      (clk),
         .rst      (rst_l[g]),
         .i_ir_rxb (ir_l[g]),
         .o_data   (data_l[g]),
         .o_valid  (valid_l[g]),
         .o_repeat (rpt_l[g]),
         .o_err    (err_l[g])
      );
   end

   // Pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int l = 0; l < NL; l++) begin
         if (valid_l[l]) n_valid[l] <= n_valid[l] + 1;
         if (rpt_l[l])   n_rpt[l]   <= n_rpt[l] + 1;
         if (err_l[l]) begin
            n_err[l]   <= n_err[l] + 1;
            err_cyc[l] <= cyc;
         end
         if ((int'(valid_l[l]) + int'(rpt_l[l]) + int'(err_l[l])) > 1)
            n_multi <= n_multi + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int l, input logic lvl, input int us);
      ir_l[l] = lvl;
      repeat (us) @(negedge clk);
   endtask

   // Space with optional 2 us low glitches every 300 us.
   task automatic space_g(input int l, input int us, input bit glitch);
      for (int t = 0; t < us; t++) begin
         ir_l[l] = (glitch && ((t % 300) == 150 || (t % 300) == 151)) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic send_bits(input int l, input logic [31:0] d, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         hold(l, 1'b0, 560);
         space_g(l, d[i] ? 1690 : 560, glitch);
      end
   endtask

   task automatic send_frame(input int l, input logic [31:0] d, input bit glitch);
      hold(l, 1'b0, 9000);
      hold(l, 1'b1, 4500);
      send_bits(l, d, 32, glitch);
      hold(l, 1'b0, 560);
      hold(l, 1'b1, 200);
   endtask

   task automatic send_repeat(input int l);
      hold(l, 1'b0, 9000);
      hold(l, 1'b1, 2250);
      hold(l, 1'b0, 560);
      hold(l, 1'b1, 200);
   endtask

   initial begin
      logic [31:0] good;
      logic [31:0] bad;
      good = {~8'h45, 8'h45, ~8'h00, 8'h00};   // 0xBA45FF00
      bad  = {8'hBB, 8'h45, 8'hFF, 8'h00};     // 0xBB45FF00
      for (int l = 0; l < NL; l++) begin
         rst_l[l] = 1'b1;
         ir_l[l]  = 1'b1;
      end
      repeat (5) @(negedge clk);
      for (int l = 0; l < NL; l++) rst_l[l] = 1'b0;
      @(negedge clk);

      check("rst_data",   data_l[0], 32'h0);
      check("rst_valid",  32'(valid_l[0]), 32'd0);
      check("rst_repeat", 32'(rpt_l[0]), 32'd0);
      check("rst_err",    32'(err_l[0]), 32'd0);

      fork
         begin : lane0
            send_frame(0, good, 1'b0);
            check("frame_valid_cnt", 32'(n_valid[0]), 32'd1);
            check("frame_data",      data_l[0], 32'hBA45FF00);
            check("frame_err_cnt",   32'(n_err[0]), 32'd0);
            check("frame_rpt_cnt",   32'(n_rpt[0]), 32'd0);
            hold(0, 1'b1, 1000);
            send_repeat(0);
            check("rpt_cnt",        32'(n_rpt[0]), 32'd1);
            check("rpt_data_kept",  data_l[0], 32'hBA45FF00);
            check("rpt_valid_cnt",  32'(n_valid[0]), 32'd1);
            check("rpt_err_cnt",    32'(n_err[0]), 32'd0);
         end
         begin : lane1
            send_frame(1, bad, 1'b0);
`ifdef IR_NEC_CHECKSUM_EN
            check("csum_valid_cnt", 32'(n_valid[1]), 32'd0);
            check("csum_err_cnt",   32'(n_err[1]), 32'd1);
            check("csum_data",      data_l[1], 32'h0);
`else
            check("ext_valid_cnt",  32'(n_valid[1]), 32'd1);
            check("ext_err_cnt",    32'(n_err[1]), 32'd0);
            check("ext_data",       data_l[1], 32'hBB45FF00);
`endif
         end
         begin : lane2
            int t0;
            hold(2, 1'b0, 9000);
            hold(2, 1'b1, 4500);
            send_bits(2, good, 10, 1'b0);
            hold(2, 1'b0, 560);
            ir_l[2] = 1'b1;
            t0 = cyc;
            hold(2, 1'b1, 15000);
            check("tmo_err_cnt",   32'(n_err[2]), 32'd1);
            check("tmo_window",    32'((err_cyc[2] - t0 >= 12000) && (err_cyc[2] - t0 <= 12025)), 32'd1);
            check("tmo_valid_cnt", 32'(n_valid[2]), 32'd0);
            hold(2, 1'b0, 5000);
            hold(2, 1'b1, 200);
            check("short_lead_err", 32'(n_err[2]), 32'd2);
            send_repeat(2);
            check("rpt_noframe_err", 32'(n_err[2]), 32'd3);
            check("rpt_noframe_rpt", 32'(n_rpt[2]), 32'd0);
            check("rpt_noframe_data", data_l[2], 32'h0);
         end
         begin : lane3
            send_frame(3, good, 1'b1);
            check("glitch_valid_cnt", 32'(n_valid[3]), 32'd1);
            check("glitch_data",      data_l[3], 32'hBA45FF00);
            check("glitch_err_cnt",   32'(n_err[3]), 32'd0);
         end
         begin : lane4
            hold(4, 1'b0, 9000);
            hold(4, 1'b1, 4500);
            send_bits(4, good, 20, 1'b0);
            rst_l[4] = 1'b1;
            repeat (5) @(negedge clk);
            rst_l[4] = 1'b0;
            hold(4, 1'b1, 15000);
            check("midrst_valid_cnt", 32'(n_valid[4]), 32'd0);
            check("midrst_err_cnt",   32'(n_err[4]), 32'd0);
            check("midrst_rpt_cnt",   32'(n_rpt[4]), 32'd0);
            check("midrst_data",      data_l[4], 32'h0);
         end
      join

      repeat (5) @(negedge clk);
      check("pulses_exclusive", 32'(n_multi), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_nec_rx.md
IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, SHALL set the system clock frequency used to derive the internal 1 us tick (divide by CLK_HZ/1000000).
REQ-002 Parameter GLITCH_US, default 4, SHALL set the number of consecutive 1 us ticks the input must be stable before a level change is accepted.
REQ-003 Parameter TIMEOUT_US, default 12000, SHALL set the maximum space duration inside a frame before abort.
REQ-004 clk  input  1  SHALL be the single system clock; all flops are clocked on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 i_ir_rxb  input  1  SHALL be the asynchronous, active-low IR receiver output (idle high, mark = low).
REQ-007 o_data  output  32  SHALL hold the last accepted frame, {~cmd, cmd, ~addr, addr}, with the first received bit in o_data[0].
REQ-008 o_valid  output  1  SHALL pulse high one clk when o_data is updated with a new frame.
REQ-009 o_repeat  output  1  SHALL pulse high one clk on an accepted NEC repeat code.
REQ-010 o_err  output  1  SHALL pulse high one clk on any aborted frame.

Function
REQ-011 Input SHALL pass a 2-flop synchronizer, then the GLITCH_US filter, giving filtered mark signal m (1 = mark).
REQ-012 A 16-bit saturating duration counter SHALL count 1 us ticks since the last edge of m, clear on each edge, saturate at 0xFFFF.
REQ-013 FSM states SHALL be IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK; evaluation SHALL occur on edges of m using the duration just ended.
REQ-014 IDLE -> LEAD_MARK on m rising edge.
REQ-015 LEAD_MARK: mark 8000-10000 us -> LEAD_SPACE; otherwise -> IDLE with o_err.
REQ-016 LEAD_SPACE: space 4000-5000 us -> BIT_MARK, bit index cleared; space 2000-2500 us -> RPT_MARK; otherwise -> IDLE with o_err.
REQ-017 BIT_MARK: mark 400-700 us -> BIT_SPACE; otherwise -> IDLE with o_err.
REQ-018 BIT_SPACE: space 400-700 us SHALL shift in 0, 1400-1900 us SHALL shift in 1 (LSB first); any other length -> IDLE with o_err.
REQ-019 After the 32nd bit (space ends on m rising), shift register SHALL load o_data and o_valid SHALL pulse in the following clk; FSM -> IDLE (stop mark ignored).
REQ-020 RPT_MARK: mark 400-700 us and a frame accepted since reset -> o_repeat pulse on the following clk, -> IDLE; no prior frame or bad mark -> IDLE with o_err.
REQ-021 Any state other than IDLE SHALL abort to IDLE with o_err when the current space exceeds TIMEOUT_US, without waiting for an edge.
REQ-022 o_valid, o_repeat, o_err SHALL be mutually exclusive in any cycle; o_data SHALL not change on error or repeat.
REQ-023 Window bounds SHALL be inclusive; all comparisons on the 16-bit counter.

Reset
REQ-024 rst SHALL clear o_data to 0, o_valid/o_repeat/o_err to 0, FSM to IDLE, bit index, shift register, counters, tick divider and the frame-seen flag.
REQ-025 Synchronizer and filter SHALL reset to the idle (no mark) level so no spurious edge follows reset.
REQ-026 Reset mid-frame SHALL discard the partial frame with no o_err pulse.

Configuration
REQ-027 With IR_NEC_CHECKSUM_EN defined, a 32-bit frame SHALL be accepted only if byte1 == ~byte0 and byte3 == ~byte2; failure SHALL pulse o_err and leave o_data unchanged.
REQ-028 Without IR_NEC_CHECKSUM_EN, every complete 32-bit frame SHALL be accepted (supports extended-address NEC).

Verification
REQ-029 Frame addr 0x00, cmd 0x45 (bytes 00 FF 45 BA) -> single o_valid pulse, o_data = 0xBA45FF00, o_err never high.
REQ-030 Same frame then 9000 us mark / 2250 us space / 560 us mark after 40 ms -> one o_repeat pulse, o_data still 0xBA45FF00.
REQ-031 Repeat code after reset with no prior frame -> o_err pulse, no o_repeat.
REQ-032 With IR_NEC_CHECKSUM_EN, bytes 00 FF 45 BB -> o_err pulse, o_valid low, o_data unchanged; without macro -> o_valid, o_data = 0xBB45FF00.
REQ-033 Input stays idle 15000 us after bit 10 -> o_err pulse at 12000 us (+/- filter latency), FSM IDLE, next good frame accepted.
REQ-034 2 us low glitches every 300 us during bit spaces -> ignored, frame 0xBA45FF00 accepted; rst asserted at bit 20 -> no outputs, no o_err.
